// File: rtl/wch_fht_peak_if.sv
// wch_fht_peak_if: bundle between the FHT butterfly block and the peak finder.
//   PreFhtStar      FHT start strobe (shared with the FHT block)
//   Fht0..Fht15     FHT results, two's complement, DW bits each
//   Threshold       unsigned magnitude threshold
//   PeakValid       one-cycle pulse, result fields updated
//   PeakIdx         winning index 0..15
//   PeakMag         saturated magnitude of the winner
//   PeakSign        winner was negative
//   AboveThr        PeakMag > Threshold
//   Busy            capture through PeakValid, inclusive
//   Overrun         one-cycle pulse, a capture was dropped
// master = FHT/decision side, slave = peak finder.
interface wch_fht_peak_if #(
    parameter int DW = 16
);
    logic          PreFhtStar;
    logic [DW-1:0] Fht0, Fht1, Fht2, Fht3, Fht4, Fht5, Fht6, Fht7;
    logic [DW-1:0] Fht8, Fht9, Fht10, Fht11, Fht12, Fht13, Fht14, Fht15;
    logic [DW-1:0] Threshold;
    logic          PeakValid;
    logic [3:0]    PeakIdx;
    logic [DW-1:0] PeakMag;
    logic          PeakSign;
    logic          AboveThr;
    logic          Busy;
    logic          Overrun;

    modport master (
        output PreFhtStar, Threshold,
        output Fht0, Fht1, Fht2, Fht3, Fht4, Fht5, Fht6, Fht7,
        output Fht8, Fht9, Fht10, Fht11, Fht12, Fht13, Fht14, Fht15,
        input  PeakValid, PeakIdx, PeakMag, PeakSign, AboveThr, Busy, Overrun
    );

    modport slave (
        input  PreFhtStar, Threshold,
        input  Fht0, Fht1, Fht2, Fht3, Fht4, Fht5, Fht6, Fht7,
        input  Fht8, Fht9, Fht10, Fht11, Fht12, Fht13, Fht14, Fht15,
        output PeakValid, PeakIdx, PeakMag, PeakSign, AboveThr, Busy, Overrun
    );
endinterface

// File: rtl/wch_fht_peak.sv
// wch_fht_peak: waits out the FHT latency after PreFhtStar, snapshots the
// sixteen FHT results and scans them one per clock for the largest
// saturated magnitude (ties keep the lowest index).
//   Clk    system clock, rising edge
//   Reset  asynchronous, active-low
//   bus    wch_fht_peak_if.slave (strobe, FHT results, threshold, results)
module wch_fht_peak #(
    parameter int DW      = 16,
    parameter int FHT_LAT = 5
) (
    input logic            Clk,
    input logic            Reset,
    wch_fht_peak_if.slave  bus
);
    localparam int CW = (FHT_LAT > 1) ? $clog2(FHT_LAT) : 1;
    localparam logic [CW-1:0] DLY_LOAD = CW'(FHT_LAT - 1);
    localparam logic [DW-1:0] MIN_NEG  = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] MAX_POS  = {1'b0, {(DW-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, WAIT, SCAN} state_t;

    state_t        state;
    logic          dly_run;
    logic [CW-1:0] dly_cnt;
    logic [3:0]    scan_idx;
    logic [DW-1:0] snap [16];
    logic [DW-1:0] run_max;
    logic [3:0]    run_idx;
    logic          run_sgn;

    logic          pk_valid, pk_sign, pk_above, pk_busy, pk_ovr;
    logic [3:0]    pk_idx;
    logic [DW-1:0] pk_mag;

    logic [DW-1:0] fht_in [16];
    logic [DW-1:0] cur, cur_mag, best_mag;
    logic [3:0]    best_idx;
    logic          best_sgn, take, cap_evt, last;

    function automatic logic [DW-1:0] abs_sat(input logic [DW-1:0] x);
        if (!x[DW-1])
            return x;
        if (x == MIN_NEG)
            return MAX_POS;
        return (~x) + DW'(1);
    endfunction

    always_comb begin
        fht_in[0]  = bus.Fht0;   fht_in[1]  = bus.Fht1;
        fht_in[2]  = bus.Fht2;   fht_in[3]  = bus.Fht3;
        fht_in[4]  = bus.Fht4;   fht_in[5]  = bus.Fht5;
        fht_in[6]  = bus.Fht6;   fht_in[7]  = bus.Fht7;
        fht_in[8]  = bus.Fht8;   fht_in[9]  = bus.Fht9;
        fht_in[10] = bus.Fht10;  fht_in[11] = bus.Fht11;
        fht_in[12] = bus.Fht12;  fht_in[13] = bus.Fht13;
        fht_in[14] = bus.Fht14;  fht_in[15] = bus.Fht15;
    end

    // Countdown expiry; a fresh strobe on the same edge restarts the FHT
    // and therefore wins over the capture.
    assign cap_evt = dly_run && (dly_cnt == '0) && !bus.PreFhtStar;
    assign last    = (scan_idx == 4'd15);

    always_comb begin
        cur      = snap[scan_idx];
        cur_mag  = abs_sat(cur);
        take     = (scan_idx == '0) || (cur_mag > run_max);
        best_mag = take ? cur_mag     : run_max;
        best_idx = take ? scan_idx    : run_idx;
        best_sgn = take ? cur[DW-1]   : run_sgn;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            dly_run  <= 1'b0;
            dly_cnt  <= '0;
            scan_idx <= '0;
            run_max  <= '0;
            run_idx  <= '0;
            run_sgn  <= 1'b0;
            pk_valid <= 1'b0;
            pk_idx   <= '0;
            pk_mag   <= '0;
            pk_sign  <= 1'b0;
            pk_above <= 1'b0;
            pk_busy  <= 1'b0;
            pk_ovr   <= 1'b0;
            for (int unsigned i = 0; i < 16; i++)
                snap[i] <= '0;
        end else begin
            pk_valid <= 1'b0;
            pk_ovr   <= 1'b0;

            // Delay counter runs independently of the scan engine so a
            // strobe during SCAN is timed correctly.
            if (bus.PreFhtStar) begin
                dly_run <= 1'b1;
                dly_cnt <= DLY_LOAD;
            end else if (dly_run) begin
                if (dly_cnt == '0)
                    dly_run <= 1'b0;
                else
                    dly_cnt <= dly_cnt - 1'b1;
            end

            case (state)
                IDLE: begin
                    pk_busy <= 1'b0;
                    if (bus.PreFhtStar)
                        state <= WAIT;
                end
                WAIT: begin
                    pk_busy <= cap_evt;
                    if (cap_evt) begin
                        for (int unsigned i = 0; i < 16; i++)
                            snap[i] <= fht_in[i];
                        scan_idx <= '0;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    pk_busy <= 1'b1;
                    run_max <= best_mag;
                    run_idx <= best_idx;
                    run_sgn <= best_sgn;
                    if (last) begin
                        pk_valid <= 1'b1;
                        pk_idx   <= best_idx;
                        pk_mag   <= best_mag;
                        pk_sign  <= best_sgn;
                        pk_above <= (best_mag > bus.Threshold);
                        // Capture landing on the final scan edge is accepted.
                        if (cap_evt) begin
                            for (int unsigned i = 0; i < 16; i++)
                                snap[i] <= fht_in[i];
                            scan_idx <= '0;
                            state    <= SCAN;
                        end else if (bus.PreFhtStar || dly_run) begin
                            state <= WAIT;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        scan_idx <= scan_idx + 1'b1;
                        if (cap_evt)
                            pk_ovr <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.PeakValid = pk_valid;
    assign bus.PeakIdx   = pk_idx;
    assign bus.PeakMag   = pk_mag;
    assign bus.PeakSign  = pk_sign;
    assign bus.AboveThr  = pk_above;
    assign bus.Busy      = pk_busy;
    assign bus.Overrun   = pk_ovr;
endmodule

// File: tb/tb_wch_fht_peak.sv
module tb_wch_fht_peak;
    logic Clk = 1'b0;
    logic Reset = 1'b0;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    logic signed [15:0] fv [16];

    typedef struct {
        int         c;
        logic [3:0] idx;
        logic [15:0] mag;
        logic       sgn;
        logic       thr;
    } pv_t;
    pv_t pv_q[$];
    int  ov_q[$];

    wch_fht_peak_if #(.DW(16)) bus ();

    wch_fht_peak #(.DW(16), .FHT_LAT(5)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    assign bus.Fht0  = fv[0];   assign bus.Fht1  = fv[1];
    assign bus.Fht2  = fv[2];   assign bus.Fht3  = fv[3];
    assign bus.Fht4  = fv[4];   assign bus.Fht5  = fv[5];
    assign bus.Fht6  = fv[6];   assign bus.Fht7  = fv[7];
    assign bus.Fht8  = fv[8];   assign bus.Fht9  = fv[9];
    assign bus.Fht10 = fv[10];  assign bus.Fht11 = fv[11];
    assign bus.Fht12 = fv[12];  assign bus.Fht13 = fv[13];
    assign bus.Fht14 = fv[14];  assign bus.Fht15 = fv[15];

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    // Event log: edge number after which PeakValid / Overrun were seen high.
    always @(negedge Clk) begin
        if (Reset && bus.PeakValid)
            pv_q.push_back('{cyc, bus.PeakIdx, bus.PeakMag, bus.PeakSign, bus.AboveThr});
        if (Reset && bus.Overrun)
            ov_q.push_back(cyc);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference: largest saturated |x|, first index holding it.
    function automatic void model(output int eidx, output int emag, output bit esgn);
        int m [16];
        int best;
        best = -1;
        for (int i = 0; i < 16; i++) begin
            m[i] = (int'(fv[i]) < 0) ? -int'(fv[i]) : int'(fv[i]);
            if (m[i] > 32767) m[i] = 32767;
            if (m[i] > best) best = m[i];
        end
        eidx = 0;
        for (int i = 15; i >= 0; i--)
            if (m[i] == best) eidx = i;
        emag = best;
        esgn = (fv[eidx] < 0);
    endfunction

    task automatic wait_until(input int e);
        while (cyc < e) @(negedge Clk);
    endtask

    task automatic strobe_at(input int e);
        wait_until(e - 1);
        bus.PreFhtStar = 1'b1;
        wait_until(e);
        bus.PreFhtStar = 1'b0;
    endtask

    task automatic fill_small(input int span);
        for (int i = 0; i < 16; i++)
            fv[i] = 16'(int'($urandom_range(0, 2 * span)) - span);
    endtask

    task automatic scramble();
        for (int i = 0; i < 16; i++)
            fv[i] = 16'($urandom);
    endtask

    task automatic test_reset();
        bus.PreFhtStar = 1'b0;
        bus.Threshold  = '0;
        for (int i = 0; i < 16; i++) fv[i] = 16'sd1000;
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        tests_run++;
        if ({bus.PeakValid, bus.PeakIdx, bus.PeakMag, bus.PeakSign, bus.AboveThr, bus.Busy, bus.Overrun} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got v=%b i=%0d m=%0d s=%b a=%b b=%b o=%b expected all 0",
                     bus.PeakValid, bus.PeakIdx, bus.PeakMag, bus.PeakSign, bus.AboveThr, bus.Busy, bus.Overrun);
        end
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        tests_run++;
        if (bus.PeakValid !== 1'b0 || bus.Busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_after_reset: got v=%b b=%b expected 0 0", bus.PeakValid, bus.Busy);
        end
    endtask

    task automatic test_single(input int thr);
        int k, ei, em; bit es;
        fill_small(10);
        fv[5] = 16'sd300;
        bus.Threshold = 16'(thr);
        model(ei, em, es);
        pv_q.delete(); ov_q.delete();
        k = cyc + 1;
        strobe_at(k);
        wait_until(k + 4);
        tests_run++;
        if (bus.Busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy_pre: got %b expected 0", bus.Busy); end
        wait_until(k + 5);
        tests_run++;
        if (bus.Busy !== 1'b1) begin tests_failed++; $display("FAIL single_busy_cap: got %b expected 1", bus.Busy); end
        scramble();
        wait_until(k + 21);
        tests_run++;
        if (bus.PeakValid !== 1'b1 || bus.Busy !== 1'b1) begin
            tests_failed++; $display("FAIL single_valid_k21: got v=%b b=%b expected 1 1", bus.PeakValid, bus.Busy);
        end
        wait_until(k + 22);
        tests_run++;
        if (bus.PeakValid !== 1'b0 || bus.Busy !== 1'b0 || bus.PeakMag !== 16'(em)) begin
            tests_failed++;
            $display("FAIL single_after: got v=%b b=%b m=%0d expected 0 0 %0d", bus.PeakValid, bus.Busy, bus.PeakMag, em);
        end
        wait_until(k + 26);
        tests_run++;
        if (pv_q.size() != 1 || ov_q.size() != 0) begin
            tests_failed++; $display("FAIL single_events: got pv=%0d ov=%0d expected 1 0", pv_q.size(), ov_q.size());
        end else begin
            tests_run++;
            if (pv_q[0].c !== k + 21 || pv_q[0].idx !== 4'd5 || pv_q[0].mag !== 16'd300 ||
                pv_q[0].sgn !== 1'b0 || pv_q[0].thr !== (em > thr)) begin
                tests_failed++;
                $display("FAIL single_result thr=%0d: got c=%0d i=%0d m=%0d s=%b a=%b expected c=%0d i=5 m=300 s=0 a=%b",
                         thr, pv_q[0].c - k, pv_q[0].idx, pv_q[0].mag, pv_q[0].sgn, pv_q[0].thr, 21, em > thr);
            end
        end
    endtask

    // Runs one capture on the current fv and checks it against the model.
    task automatic test_vector(input string name, input int exp_idx, input int exp_mag, input bit exp_sgn);
        int k, ei, em; bit es;
        model(ei, em, es);
        pv_q.delete(); ov_q.delete();
        k = cyc + 1;
        strobe_at(k);
        wait_until(k + 5);
        scramble();
        wait_until(k + 25);
        tests_run++;
        if (pv_q.size() != 1) begin
            tests_failed++; $display("FAIL %s_count: got %0d expected 1", name, pv_q.size());
        end else begin
            tests_run++;
            if (pv_q[0].c !== k + 21 || int'(pv_q[0].idx) !== ei || int'(pv_q[0].mag) !== em || pv_q[0].sgn !== es ||
                pv_q[0].thr !== (em > int'(bus.Threshold))) begin
                tests_failed++;
                $display("FAIL %s: got dt=%0d i=%0d m=%0d s=%b a=%b expected dt=21 i=%0d m=%0d s=%b",
                         name, pv_q[0].c - k, pv_q[0].idx, pv_q[0].mag, pv_q[0].sgn, pv_q[0].thr, ei, em, es);
            end
            tests_run++;
            if (exp_idx >= 0 && (int'(pv_q[0].idx) !== exp_idx || int'(pv_q[0].mag) !== exp_mag || pv_q[0].sgn !== exp_sgn)) begin
                tests_failed++;
                $display("FAIL %s_fixed: got i=%0d m=%0d s=%b expected i=%0d m=%0d s=%b",
                         name, pv_q[0].idx, pv_q[0].mag, pv_q[0].sgn, exp_idx, exp_mag, exp_sgn);
            end
        end
    endtask

    task automatic test_neg_tie();
        fill_small(100);
        fv[3] = -16'sd500; fv[9] = 16'sd500; fv[12] = -16'sd500;
        test_vector("neg_tie", 3, 500, 1'b1);
    endtask

    task automatic test_saturation();
        fill_small(100);
        fv[0] = -16'sd32768; fv[1] = 16'sd32767;
        test_vector("saturation", 0, 32767, 1'b1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 16; i++) begin
                case ($urandom_range(0, 5))
                    0: fv[i] = -16'sd32768;
                    1: fv[i] = 16'sd32767;
                    2: fv[i] = 16'(int'($urandom_range(0, 8)) - 4);
                    default: fv[i] = 16'($urandom);
                endcase
            end
            bus.Threshold = 16'($urandom);
            test_vector("random", -1, 0, 1'b0);
        end
    endtask

    task automatic test_retrigger();
        int k, ei, em; bit es;
        bus.Threshold = 16'd100;
        fill_small(50); fv[2] = 16'sd900;
        pv_q.delete(); ov_q.delete();
        k = cyc + 1;
        strobe_at(k);
        strobe_at(k + 2);
        wait_until(k + 6);
        fill_small(50); fv[11] = -16'sd700;
        model(ei, em, es);
        wait_until(k + 7);
        scramble();
        wait_until(k + 32);
        tests_run++;
        if (pv_q.size() != 1 || ov_q.size() != 0) begin
            tests_failed++; $display("FAIL retrigger_count: got pv=%0d ov=%0d expected 1 0", pv_q.size(), ov_q.size());
        end else begin
            tests_run++;
            if (pv_q[0].c !== k + 23 || int'(pv_q[0].idx) !== ei || int'(pv_q[0].mag) !== em || pv_q[0].sgn !== es) begin
                tests_failed++;
                $display("FAIL retrigger: got dt=%0d i=%0d m=%0d s=%b expected dt=23 i=%0d m=%0d s=%b",
                         pv_q[0].c - k, pv_q[0].idx, pv_q[0].mag, pv_q[0].sgn, ei, em, es);
            end
        end
    endtask

    task automatic test_overrun();
        int k, ei, em, ei2, em2; bit es, es2;
        fill_small(50); fv[7] = 16'sd1234;
        model(ei, em, es);
        pv_q.delete(); ov_q.delete();
        k = cyc + 1;
        strobe_at(k);
        wait_until(k + 5);
        scramble();
        strobe_at(k + 8);
        wait_until(k + 45);
        tests_run++;
        if (pv_q.size() != 1 || ov_q.size() != 1) begin
            tests_failed++; $display("FAIL overrun_count: got pv=%0d ov=%0d expected 1 1", pv_q.size(), ov_q.size());
        end else begin
            tests_run++;
            if (pv_q[0].c !== k + 21 || ov_q[0] !== k + 13 || int'(pv_q[0].idx) !== ei || int'(pv_q[0].mag) !== em) begin
                tests_failed++;
                $display("FAIL overrun_timing: got pv_dt=%0d ov_dt=%0d i=%0d m=%0d expected 21 13 i=%0d m=%0d",
                         pv_q[0].c - k, ov_q[0] - k, pv_q[0].idx, pv_q[0].mag, ei, em);
            end
        end
        // Second strobe whose countdown ends on the PeakValid edge.
        fill_small(50); fv[1] = -16'sd2000;
        model(ei, em, es);
        pv_q.delete(); ov_q.delete();
        k = cyc + 1;
        strobe_at(k);
        wait_until(k + 5);
        fill_small(50); fv[14] = 16'sd3000;
        model(ei2, em2, es2);
        strobe_at(k + 16);
        wait_until(k + 21);
        scramble();
        wait_until(k + 42);
        tests_run++;
        if (pv_q.size() != 2 || ov_q.size() != 0) begin
            tests_failed++; $display("FAIL late_strobe_count: got pv=%0d ov=%0d expected 2 0", pv_q.size(), ov_q.size());
        end else begin
            tests_run++;
            if (pv_q[0].c !== k + 21 || int'(pv_q[0].idx) !== ei || int'(pv_q[0].mag) !== em || pv_q[0].sgn !== es ||
                pv_q[1].c !== k + 37 || int'(pv_q[1].idx) !== ei2 || int'(pv_q[1].mag) !== em2 || pv_q[1].sgn !== es2) begin
                tests_failed++;
                $display("FAIL late_strobe: got dt=%0d/%0d i=%0d/%0d m=%0d/%0d expected 21/37 i=%0d/%0d m=%0d/%0d",
                         pv_q[0].c - k, pv_q[1].c - k, pv_q[0].idx, pv_q[1].idx, pv_q[0].mag, pv_q[1].mag, ei, ei2, em, em2);
            end
        end
    endtask

    task automatic test_back_to_back();
        int k, ei, em, ei2, em2; bit es, es2;
        fill_small(50); fv[4] = 16'sd555;
        model(ei, em, es);
        pv_q.delete(); ov_q.delete();
        k = cyc + 1;
        strobe_at(k);
        wait_until(k + 5);
        fill_small(50); fv[10] = -16'sd777;
        model(ei2, em2, es2);
        // Strobe sampled on the edge right after the PeakValid edge.
        strobe_at(k + 22);
        wait_until(k + 27);
        scramble();
        wait_until(k + 48);
        tests_run++;
        if (pv_q.size() != 2) begin
            tests_failed++; $display("FAIL b2b_count: got %0d expected 2", pv_q.size());
        end else begin
            tests_run++;
            if (pv_q[0].c !== k + 21 || int'(pv_q[0].idx) !== ei || int'(pv_q[0].mag) !== em ||
                pv_q[1].c !== k + 43 || int'(pv_q[1].idx) !== ei2 || int'(pv_q[1].mag) !== em2 || pv_q[1].sgn !== es2) begin
                tests_failed++;
                $display("FAIL b2b: got dt=%0d/%0d i=%0d/%0d m=%0d/%0d expected 21/43 i=%0d/%0d m=%0d/%0d",
                         pv_q[0].c - k, pv_q[1].c - k, pv_q[0].idx, pv_q[1].idx, pv_q[0].mag, pv_q[1].mag, ei, ei2, em, em2);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        int k;
        fill_small(50); fv[6] = 16'sd4321;
        pv_q.delete(); ov_q.delete();
        k = cyc + 1;
        strobe_at(k);
        wait_until(k + 11);
        tests_run++;
        if (bus.Busy !== 1'b1 || bus.PeakMag === 16'd0) begin
            tests_failed++; $display("FAIL midscan_pre: got b=%b m=%0d expected b=1 m!=0", bus.Busy, bus.PeakMag);
        end
        wait_until(k + 12);
        Reset = 1'b0;
        #1;
        tests_run++;
        if ({bus.PeakValid, bus.PeakIdx, bus.PeakMag, bus.PeakSign, bus.AboveThr, bus.Busy, bus.Overrun} !== '0) begin
            tests_failed++;
            $display("FAIL midscan_reset: got v=%b i=%0d m=%0d s=%b a=%b b=%b o=%b expected all 0",
                     bus.PeakValid, bus.PeakIdx, bus.PeakMag, bus.PeakSign, bus.AboveThr, bus.Busy, bus.Overrun);
        end
        @(negedge Clk);
        Reset = 1'b1;
        wait_until(k + 40);
        tests_run++;
        if (pv_q.size() != 0 || bus.Busy !== 1'b0) begin
            tests_failed++; $display("FAIL midscan_aborted: got pv=%0d b=%b expected 0 0", pv_q.size(), bus.Busy);
        end
        fill_small(50); fv[13] = -16'sd6000;
        test_vector("after_reset", 13, 6000, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) fv[i] = '0;
        bus.PreFhtStar = 1'b0;
        bus.Threshold  = '0;
        @(negedge Clk);
        test_reset();
        test_single(200);
        test_single(300);
        test_neg_tie();
        test_saturation();
        test_retrigger();
        test_overrun();
        test_back_to_back();
        test_reset_mid_scan();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
